// File: rtl/axis_mon_pkg.sv
`default_nettype none
// ============================================================================
// axis_mon_pkg : shared types, widths and helpers for the handshake monitor
// Rev 1.0
// ============================================================================
package axis_mon_pkg;

   localparam int CNT_W = 32;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      PEND = 1'b1
   } lane_state_e;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/axis_hs_lane.sv
`default_nettype none
// ============================================================================
// axis_hs_lane : one valid/ready lane - protocol checks, beat/stall counters
// Rev 1.0
// ============================================================================
module axis_hs_lane
   import axis_mon_pkg::*;
#(
   parameter int DATA_W      = 64,
   parameter int STALL_LIMIT = 1024
) (
   input  logic              user_clk,
   input  logic              user_reset,
   input  logic              enable,
   input  logic              clr_stats,
   input  logic              valid,
   input  logic              ready,
   input  logic [DATA_W-1:0] data,
   output logic [CNT_W-1:0]  xfer_cnt,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic              viol_drop,
   output logic              viol_data,
   output logic              timeout
);

   localparam int               RUN_W    = $clog2(STALL_LIMIT);
   localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(STALL_LIMIT - 1);
   localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);

   lane_state_e       state_q, state_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic [RUN_W-1:0]  run_q, run_d;
   logic [CNT_W-1:0]  xfer_q, xfer_d;
   logic [CNT_W-1:0]  stall_q, stall_d;
   logic              drop_q, drop_d;
   logic              vdata_q, vdata_d;
   logic              tout_q, tout_d;

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      run_d   = run_q;
      xfer_d  = xfer_q;
      stall_d = stall_q;
      drop_d  = drop_q;
      vdata_d = vdata_q;
      tout_d  = tout_q;

      if (enable) begin
         if (valid && ready)  xfer_d  = sat_inc(xfer_q);
         if (valid && !ready) stall_d = sat_inc(stall_q);

         unique case (state_q)
            IDLE: begin
               // The offering cycle is the first stall of the run.
               if (valid && !ready) begin
                  state_d = PEND;
                  hold_d  = data;
                  run_d   = RUN_ONE;
               end
            end
            PEND: begin
               if (!valid) begin
                  state_d = IDLE;
                  run_d   = '0;
                  drop_d  = 1'b1;
               end else begin
                  if (data != hold_q) vdata_d = 1'b1;
                  if (ready) begin
                     state_d = IDLE;
                     run_d   = '0;
                  end else if (run_q == RUN_LAST) begin
                     tout_d = 1'b1;
                  end else begin
                     run_d = run_q + RUN_ONE;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end

      // A clear outranks any same-cycle increment or flag event.
      if (clr_stats) begin
         xfer_d  = '0;
         stall_d = '0;
         drop_d  = 1'b0;
         vdata_d = 1'b0;
         tout_d  = 1'b0;
      end
   end

   always_ff @(posedge user_clk) begin
      if (user_reset) begin
         state_q <= IDLE;
         hold_q  <= '0;
         run_q   <= '0;
         xfer_q  <= '0;
         stall_q <= '0;
         drop_q  <= 1'b0;
         vdata_q <= 1'b0;
         tout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         run_q   <= run_d;
         xfer_q  <= xfer_d;
         stall_q <= stall_d;
         drop_q  <= drop_d;
         vdata_q <= vdata_d;
         tout_q  <= tout_d;
      end
   end

   assign xfer_cnt  = xfer_q;
   assign stall_cnt = stall_q;
   assign viol_drop = drop_q;
   assign viol_data = vdata_q;
   assign timeout   = tout_q;

endmodule
`default_nettype wire

// File: rtl/axis_handshake_monitor.sv
`default_nettype none
// ============================================================================
// axis_handshake_monitor : multi-lane AXI-Stream handshake checker and stats
// Rev 1.0
// ============================================================================
module axis_handshake_monitor
   import axis_mon_pkg::*;
#(
   parameter int NUM_INTFC   = 4,
   parameter int DATA_W      = 64,
   parameter int STALL_LIMIT = 1024,
   parameter int TCQ         = 1
) (
   input  logic                        user_clk,
   input  logic                        user_reset,
   input  logic                        enable,
   input  logic                        clr_stats,
   input  logic [NUM_INTFC-1:0]        valid,
   input  logic [NUM_INTFC-1:0]        ready,
   input  logic [NUM_INTFC*DATA_W-1:0] data,
   output logic [NUM_INTFC*CNT_W-1:0]  xfer_cnt,
   output logic [NUM_INTFC*CNT_W-1:0]  stall_cnt,
   output logic [NUM_INTFC-1:0]        viol_drop,
   output logic [NUM_INTFC-1:0]        viol_data,
   output logic [NUM_INTFC-1:0]        timeout,
   output logic                        err_any
);

   // TCQ is a simulation-only clock-to-q figure; it is not modelled in logic.
   if (STALL_LIMIT < 2 || TCQ < 0) begin : g_param_check
      $error("axis_handshake_monitor: STALL_LIMIT must be >= 2 and TCQ >= 0");
   end

   for (genvar i = 0; i < NUM_INTFC; i++) begin : g_lane
      axis_hs_lane #(
         .DATA_W      (DATA_W),
         .STALL_LIMIT (STALL_LIMIT)
      ) u_lane (
         .user_clk   (user_clk),
         .user_reset (user_reset),
         .enable     (enable),
         .clr_stats  (clr_stats),
         .valid      (valid[i]),
         .ready      (ready[i]),
         .data       (data[i*DATA_W +: DATA_W]),
         .xfer_cnt   (xfer_cnt[i*CNT_W +: CNT_W]),
         .stall_cnt  (stall_cnt[i*CNT_W +: CNT_W]),
         .viol_drop  (viol_drop[i]),
         .viol_data  (viol_data[i]),
         .timeout    (timeout[i])
      );
   end

   logic err_any_q, err_any_d;

   always_comb begin
      err_any_d = (|viol_drop) | (|viol_data) | (|timeout);
      if (clr_stats) err_any_d = 1'b0;
   end

   always_ff @(posedge user_clk) begin
      if (user_reset) err_any_q <= 1'b0;
      else            err_any_q <= err_any_d;
   end

   assign err_any = err_any_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_handshake_monitor.sv
`default_nettype none
// ============================================================================
// tb_axis_handshake_monitor : scoreboard bench with a pending-beat reference model
// Rev 1.0
// ============================================================================
module tb_axis_handshake_monitor;

   localparam int N   = 4;
   localparam int DW  = 8;
   localparam int LIM = 8;

   logic            user_clk;
   logic            user_reset;
   logic            enable;
   logic            clr_stats;
   logic [N-1:0]    valid;
   logic [N-1:0]    ready;
   logic [N*DW-1:0] data;
   logic [N*32-1:0] xfer_cnt;
   logic [N*32-1:0] stall_cnt;
   logic [N-1:0]    viol_drop;
   logic [N-1:0]    viol_data;
   logic [N-1:0]    timeout;
   logic            err_any;

   axis_handshake_monitor #(
      .NUM_INTFC   (N),
      .DATA_W      (DW),
      .STALL_LIMIT (LIM),
      .TCQ         (1)
   ) dut (
      .user_clk   (user_clk),
      .user_reset (user_reset),
      .enable     (enable),
      .clr_stats  (clr_stats),
      .valid      (valid),
      .ready      (ready),
      .data       (data),
      .xfer_cnt   (xfer_cnt),
      .stall_cnt  (stall_cnt),
      .viol_drop  (viol_drop),
      .viol_data  (viol_data),
      .timeout    (timeout),
      .err_any    (err_any)
   );

   initial user_clk = 1'b0;
   always #5 user_clk = ~user_clk;

   int cyc = 0;
   always @(posedge user_clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   // Reference model: a lane either has an outstanding offered beat or not.
   int unsigned    m_xfer  [N];
   int unsigned    m_stall [N];
   bit             m_pend  [N];
   logic [DW-1:0]  m_hold  [N];
   int             m_run   [N];
   bit             m_drop  [N];
   bit             m_vdat  [N];
   bit             m_tout  [N];
   bit             m_err;

   typedef struct {
      int              due;
      logic [N*32-1:0] xfer;
      logic [N*32-1:0] stall;
      logic [N-1:0]    drop;
      logic [N-1:0]    vdat;
      logic [N-1:0]    tout;
      logic            err;
   } exp_t;

   exp_t exp_q[$];

   task automatic model_step(input bit en, input bit clr, input bit rst,
                             input logic [N-1:0] v, input logic [N-1:0] r,
                             input logic [N*DW-1:0] d);
      exp_t e;
      bit   any;
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            m_xfer[i] = 0; m_stall[i] = 0; m_pend[i] = 0; m_hold[i] = '0;
            m_run[i] = 0;  m_drop[i] = 0;  m_vdat[i] = 0; m_tout[i] = 0;
         end
         m_err = 0;
      end else begin
         any = 0;
         for (int i = 0; i < N; i++) any = any | m_drop[i] | m_vdat[i] | m_tout[i];
         m_err = clr ? 1'b0 : any;
         for (int i = 0; i < N; i++) begin
            logic [DW-1:0] di;
            bit ev_drop, ev_data, ev_tout;
            di = d[i*DW +: DW];
            ev_drop = 0; ev_data = 0; ev_tout = 0;
            if (en) begin
               if (m_pend[i]) begin
                  if (!v[i]) begin
                     ev_drop = 1; m_pend[i] = 0; m_run[i] = 0;
                  end else begin
                     if (di != m_hold[i]) ev_data = 1;
                     if (r[i]) begin
                        m_pend[i] = 0; m_run[i] = 0;
                     end else begin
                        m_run[i]++;
                        if (m_run[i] >= LIM) ev_tout = 1;
                     end
                  end
               end else if (v[i] && !r[i]) begin
                  m_pend[i] = 1; m_hold[i] = di; m_run[i] = 1;
               end
               if (v[i] && r[i]  && m_xfer[i]  != 32'hFFFF_FFFF) m_xfer[i]++;
               if (v[i] && !r[i] && m_stall[i] != 32'hFFFF_FFFF) m_stall[i]++;
            end
            if (clr) begin
               m_xfer[i] = 0; m_stall[i] = 0; m_drop[i] = 0; m_vdat[i] = 0; m_tout[i] = 0;
            end else begin
               m_drop[i] = m_drop[i] | ev_drop;
               m_vdat[i] = m_vdat[i] | ev_data;
               m_tout[i] = m_tout[i] | ev_tout;
            end
         end
      end
      for (int i = 0; i < N; i++) begin
         e.xfer[i*32 +: 32]  = m_xfer[i];
         e.stall[i*32 +: 32] = m_stall[i];
         e.drop[i] = m_drop[i];
         e.vdat[i] = m_vdat[i];
         e.tout[i] = m_tout[i];
      end
      e.err = m_err;
      e.due = cyc + 1;
      exp_q.push_back(e);
   endtask

   // Drive one cycle of stimulus just after a rising edge and record its expectation.
   task automatic drive(input bit en, input bit clr, input bit rst,
                        input logic [N-1:0] v, input logic [N-1:0] r,
                        input logic [N*DW-1:0] d);
      @(posedge user_clk);
      #1;
      enable = en; clr_stats = clr; user_reset = rst;
      valid = v; ready = r; data = d;
      model_step(en, clr, rst, v, r, d);
   endtask

   task automatic one(input int lane, input bit v, input bit r, input logic [DW-1:0] db,
                      input bit clr, input bit rst);
      logic [N-1:0]    vv;
      logic [N-1:0]    rr;
      logic [N*DW-1:0] dd;
      vv = '0; rr = '0; dd = '0;
      vv[lane] = v; rr[lane] = r; dd[lane*DW +: DW] = db;
      drive(1'b1, clr, rst, vv, rr, dd);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
   endtask

   // Monitor: outputs are compared on the falling edge once their edge has passed.
   initial begin
      exp_t e;
      forever begin
         @(negedge user_clk);
         while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            e = exp_q.pop_front();
            for (int i = 0; i < N; i++) begin
               cmp($sformatf("xfer_cnt[%0d]", i),  xfer_cnt[i*32 +: 32],  e.xfer[i*32 +: 32]);
               cmp($sformatf("stall_cnt[%0d]", i), stall_cnt[i*32 +: 32], e.stall[i*32 +: 32]);
            end
            cmp("viol_drop", 32'(viol_drop), 32'(e.drop));
            cmp("viol_data", 32'(viol_data), 32'(e.vdat));
            cmp("timeout",   32'(timeout),   32'(e.tout));
            cmp("err_any",   32'(err_any),   32'(e.err));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete (expected completion)");
      $fatal(1, "watchdog expired");
   end

   initial begin
      user_reset = 1'b1; enable = 1'b0; clr_stats = 1'b0;
      valid = '0; ready = '0; data = '0;

      drive(1'b0, 1'b0, 1'b1, '0, '0, '0);
      drive(1'b0, 1'b0, 1'b1, '0, '0, '0);
      idle(1);
      @(negedge user_clk);
      cmp("dir_reset_xfer",  xfer_cnt[31:0], 32'd0);
      cmp("dir_reset_flags", 32'({viol_drop, viol_data, timeout, err_any}), 32'd0);

      // Lane 0: ten back-to-back beats.
      for (int k = 0; k < 10; k++) one(0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
      idle(1);
      @(negedge user_clk);
      cmp("dir_l0_xfer",  xfer_cnt[31:0],  32'd10);
      cmp("dir_l0_stall", stall_cnt[31:0], 32'd0);

      // Lane 1: three stalls then a completing beat.
      for (int k = 0; k < 3; k++) one(1, 1'b1, 1'b0, 8'h22, 1'b0, 1'b0);
      one(1, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0);
      idle(1);
      @(negedge user_clk);
      cmp("dir_l1_stall", stall_cnt[63:32], 32'd3);
      cmp("dir_l1_xfer",  xfer_cnt[63:32],  32'd1);
      cmp("dir_l1_flags", 32'({viol_drop, viol_data, timeout}), 32'd0);

      // Lane 2: payload changes while pending.
      one(2, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0);
      one(2, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);
      one(2, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
      idle(1);
      @(negedge user_clk);
      cmp("dir_l2_vdata", 32'(viol_data), 32'h4);
      cmp("dir_l2_err",   32'(err_any),   32'd1);

      // Lane 3: valid withdrawn before ready.
      one(3, 1'b1, 1'b0, 8'h33, 1'b0, 1'b0);
      one(3, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0);
      idle(1);
      @(negedge user_clk);
      cmp("dir_l3_drop", 32'(viol_drop), 32'h8);
      cmp("dir_l3_tout", 32'(timeout),   32'h0);

      // Clear coinciding with a beat.
      one(0, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0);
      idle(1);
      @(negedge user_clk);
      cmp("dir_clr_xfer",  xfer_cnt[31:0],   32'd0);
      cmp("dir_clr_stall", stall_cnt[63:32], 32'd0);
      cmp("dir_clr_flags", 32'({viol_drop, viol_data, timeout, err_any}), 32'd0);

      // Stall-limit boundary: seven stalls are tolerated, eight are not.
      for (int k = 0; k < LIM - 1; k++) one(0, 1'b1, 1'b0, 8'h44, 1'b0, 1'b0);
      one(0, 1'b1, 1'b1, 8'h44, 1'b0, 1'b0);
      idle(1);
      @(negedge user_clk);
      cmp("dir_stall7_tout", 32'(timeout), 32'h0);
      for (int k = 0; k < LIM; k++) one(0, 1'b1, 1'b0, 8'h55, 1'b0, 1'b0);
      one(0, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
      idle(1);
      @(negedge user_clk);
      cmp("dir_stall8_tout",  32'(timeout),     32'h1);
      cmp("dir_stall8_count", stall_cnt[31:0], 32'd15);

      // Reset while a beat is pending: the beat is discarded silently.
      for (int k = 0; k < 2; k++) one(1, 1'b1, 1'b0, 8'h66, 1'b0, 1'b0);
      one(1, 1'b1, 1'b0, 8'h66, 1'b0, 1'b1);
      one(1, 1'b0, 1'b0, 8'h66, 1'b0, 1'b0);
      idle(1);
      @(negedge user_clk);
      cmp("dir_rstpend_flags", 32'({viol_drop, viol_data, timeout, err_any}), 32'd0);
      cmp("dir_rstpend_stall", stall_cnt[63:32], 32'd0);

      // Randomised traffic with varying backpressure.
      for (int blk = 0; blk < 8; blk++) begin
         int rdy_pct;
         rdy_pct = (blk % 4 == 0) ? 60 : (blk % 4 == 1) ? 15 : (blk % 4 == 2) ? 3 : 85;
         for (int c = 0; c < 250; c++) begin
            logic [N-1:0]    v;
            logic [N-1:0]    r;
            logic [N*DW-1:0] d;
            bit en, clr, rst;
            for (int i = 0; i < N; i++) begin
               logic [DW-1:0] dv;
               dv = DW'($urandom);
               if (m_pend[i]) begin
                  v[i] = ($urandom_range(0, 15) != 0);
                  if ($urandom_range(0, 15) != 0) dv = m_hold[i];
               end else begin
                  v[i] = ($urandom_range(0, 1) == 1);
               end
               r[i] = ($urandom_range(0, 99) < rdy_pct);
               d[i*DW +: DW] = dv;
            end
            en  = ($urandom_range(0, 19) != 0);
            clr = ($urandom_range(0, 79) == 0);
            rst = ($urandom_range(0, 499) == 0);
            drive(en, clr, rst, v, r, d);
         end
      end

      idle(2);
      @(negedge user_clk);
      @(negedge user_clk);
      cmp("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
